// File: rtl/avalon_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM: byte-lane writes, 1/2-cycle pipelined reads with readdatavalid, post-reset clear.
// Define ONCHIP_MEM_PARITY_EN to store one even-parity bit per byte and report read parity errors.

module avalon_onchip_ram_lane #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wbyte,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rbyte
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic          perr
`endif
);
`ifdef ONCHIP_MEM_PARITY_EN
  localparam int MW = 9;
  logic [MW-1:0] wword;
  assign wword = {^wbyte, wbyte};
`else
  localparam int MW = 8;
  logic [MW-1:0] wword;
  assign wword = wbyte;
`endif

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rword;

  // Read register only loads on an accepted read so the output holds between reads.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wword;
    if (re) rword <= mem[raddr];
  end

  assign rbyte = rword[7:0];
`ifdef ONCHIP_MEM_PARITY_EN
  assign perr = ^rword;
`endif
endmodule

module avalon_onchip_ram_pipelined #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int DEPTH          = 38400,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    busy
`ifdef ONCHIP_MEM_PARITY_EN
  ,
  output logic                    parity_err,
  output logic                    parity_err_sticky
`endif
);
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [AW-1:0]       LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                           state;
  logic [AW-1:0]                    clr_addr;
  logic                             in_range, acc, acc_wr, acc_rd, clr_we;
  logic [AW-1:0]                    waddr;
  logic [NUM_LANES-1:0]             lane_we;
  logic [NUM_LANES-1:0][7:0]        lane_wdata;
  logic [NUM_LANES-1:0][7:0]        lane_rdata;
  logic [READ_LATENCY:1]            vld_pipe;
  logic                             rng1;
  logic [DATA_WIDTH-1:0]            s1_data;
`ifdef ONCHIP_MEM_PARITY_EN
  logic [NUM_LANES-1:0]             lane_perr;
  logic                             s1_perr, perr_out;
`endif

  assign waitrequest = busy | ~clken | reset_req;
  assign in_range    = ({1'b0, address} < DEPTH_W);
  assign acc         = chipselect & (read | write) & ~waitrequest & ~reset;
  assign acc_wr      = acc & write;
  assign acc_rd      = acc & ~write;
  assign clr_we      = (state == ST_CLEAR) & clken & ~reset;
  assign waddr       = clr_we ? clr_addr : address[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy     <= (CLEAR_ON_RESET != 0);
      clr_addr <= '0;
    end else if (clken && state == ST_CLEAR) begin
      if (clr_addr == LAST) begin
        state    <= ST_IDLE;
        busy     <= 1'b0;
        clr_addr <= '0;
      end else begin
        clr_addr <= clr_addr + AW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_we[i]    = clr_we | (acc_wr & in_range & byteenable[i]);
    assign lane_wdata[i] = clr_we ? 8'h00 : writedata[i*8 +: 8];

    avalon_onchip_ram_lane #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .waddr (waddr),
      .wbyte (lane_wdata[i]),
      .re    (acc_rd),
      .raddr (address[AW-1:0]),
      .rbyte (lane_rdata[i])
`ifdef ONCHIP_MEM_PARITY_EN
      ,
      .perr  (lane_perr[i])
`endif
    );
  end

  // Out-of-range reads still flow down the pipe; their data is masked to zero here.
  assign s1_data = rng1 ? lane_rdata : '0;
`ifdef ONCHIP_MEM_PARITY_EN
  assign s1_perr = rng1 & (|lane_perr);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      rng1     <= 1'b0;
    end else if (clken) begin
      vld_pipe[1] <= acc_rd;
      for (int s = 2; s <= READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
      if (acc_rd) rng1 <= in_range;
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign readdata = s1_data;
`ifdef ONCHIP_MEM_PARITY_EN
    assign perr_out = s1_perr;
`endif
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  perr_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_q   <= '0;
        perr_q <= 1'b0;
      end else if (clken && vld_pipe[1]) begin
        rd_q   <= s1_data;
`ifdef ONCHIP_MEM_PARITY_EN
        perr_q <= s1_perr;
`endif
      end
    end
    assign readdata = rd_q;
`ifdef ONCHIP_MEM_PARITY_EN
    assign perr_out = perr_q;
`endif
  end

  // A frozen pipe keeps its valid bit; gating here makes it pulse once when clken returns.
  assign readdatavalid = vld_pipe[READ_LATENCY] & clken;

`ifdef ONCHIP_MEM_PARITY_EN
  assign parity_err = readdatavalid & perr_out;

  always_ff @(posedge clk) begin
    if (reset)           parity_err_sticky <= 1'b0;
    else if (parity_err) parity_err_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_avalon_onchip_ram_pipelined.sv
// Directed bench for avalon_onchip_ram_pipelined (DEPTH=16, READ_LATENCY=2) with a read scoreboard.
module tb_avalon_onchip_ram_pipelined;
  localparam int DW = 32, AWD = 8, DEPTH = 16, LAT = 2;

  logic clk = 1'b0;
  logic reset, reset_req, clken, chipselect, read, write;
  logic [AWD-1:0] address;
  logic [3:0]     byteenable;
  logic [DW-1:0]  writedata, readdata;
  logic readdatavalid, waitrequest, busy;
`ifdef ONCHIP_MEM_PARITY_EN
  logic parity_err, parity_err_sticky;
`endif

  typedef struct {
    logic [31:0] data;
    logic        perr;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [DEPTH];
  int checks = 0, errors = 0, en_cnt = 0;

  avalon_onchip_ram_pipelined #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AWD), .DEPTH(DEPTH),
    .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .read(read), .write(write), .address(address),
    .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest), .busy(busy)
`ifdef ONCHIP_MEM_PARITY_EN
    , .parity_err(parity_err), .parity_err_sticky(parity_err_sticky)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (clken === 1'b1) en_cnt <= en_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every readdatavalid pops one expectation and checks data and enabled-cycle latency.
  always @(negedge clk) begin
    exp_t e;
    if (readdatavalid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_rdv: observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data", readdata, e.data);
        chk("rd_latency", en_cnt, e.due);
`ifdef ONCHIP_MEM_PARITY_EN
        chk("parity_err", parity_err, e.perr);
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    chipselect = 0; read = 0; write = 0; byteenable = '0;
  endtask

  task automatic rd(input int a, input logic pe);
    exp_t e;
    chipselect = 1; read = 1; write = 0; address = AWD'(a);
    e.data = (a < DEPTH) ? model[a] : 32'h0;
    e.perr = pe;
    e.due  = en_cnt + LAT;
    exp_q.push_back(e);
    step();
    idle_bus();
  endtask

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1; read = 0; write = 1; address = AWD'(a);
    writedata = d; byteenable = be;
    if (a < DEPTH)
      for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
    step();
    idle_bus();
  endtask

  task automatic wait_clear(input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(tag, n, DEPTH);
    chk("wait_after_clear", waitrequest, 0);
    step();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; reset_req = 0; clken = 1; address = '0; writedata = '0;
    idle_bus();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_wait", waitrequest, 1);
    step();
    reset = 0;
    wait_clear("clear_cycles");

    for (int i = 0; i < DEPTH; i++) rd(i, 0);
    drain();

    // Partial byte-lane write over a full word.
    wr(5, 32'h11223344, 4'hF);
    wr(5, 32'hAABBCCDD, 4'b0101);
    rd(5, 0);
    drain();

    for (int i = 0; i < 4; i++) wr(i, 32'(10 + i), 4'hF);
    for (int i = 0; i < 4; i++) rd(i, 0);
    drain();

    // Read directly after write to the same word.
    wr(7, 32'hCAFEF00D, 4'hF);
    rd(7, 0);
    // Read and write together: write wins, no read response.
    chipselect = 1; read = 1; write = 1; address = 9;
    writedata = 32'h01020304; byteenable = 4'hF;
    model[9] = 32'h01020304;
    step();
    idle_bus();
    rd(9, 0);
    drain();

    // Stall with the read in the first pipe stage.
    rd(2, 0);
    clken = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_wait", waitrequest, 1);
      chk("stall_rdv", readdatavalid, 0);
      step();
    end
    clken = 1;
    drain();

    // Stall with the response already at the output stage.
    rd(3, 0);
    step();
    clken = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stall2_rdv", readdatavalid, 0);
      step();
    end
    clken = 1;
    drain();

    // reset_req blocks new commands but lets the in-flight read finish.
    rd(1, 0);
    reset_req = 1; chipselect = 1; read = 1; address = 4;
    @(negedge clk);
    chk("rreq_wait", waitrequest, 1);
    step();
    idle_bus();
    reset_req = 0;
    drain();

    wr(16, 32'hDEADBEEF, 4'hF);
    rd(16, 0);
    rd(0, 0);
    drain();

`ifdef ONCHIP_MEM_PARITY_EN
    dut.g_lane[0].u_lane.mem[3][0] = ~dut.g_lane[0].u_lane.mem[3][0];
    model[3][0] = ~model[3][0];
    rd(3, 1);
    drain();
    chk("sticky_set", parity_err_sticky, 1);
    rd(2, 0);
    drain();
    chk("sticky_hold", parity_err_sticky, 1);
`endif

    // Reset with a read in flight: the response must be discarded.
    rd(5, 0);
    exp_q.delete();
    reset = 1;
    step();
    step();
    @(negedge clk);
    chk("midrst_readdata", readdata, 0);
    chk("midrst_busy", busy, 1);
`ifdef ONCHIP_MEM_PARITY_EN
    chk("sticky_clr", parity_err_sticky, 0);
`endif
    step();
    reset = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    wait_clear("reclear_cycles");
    rd(5, 0);
    rd(16, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
